// File: rtl/toy_ram_hs.sv
// Byte-addressable little-endian RAM with valid/ready request and response channels.
// Define TOY_RAM_MISALIGN_SPLIT_EN to allow misaligned accesses (split into two beats across words).
module toy_ram_hs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int SIZE_BYTES = 4096,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    localparam int MW = (SIZE_BYTES > 1) ? $clog2(SIZE_BYTES) : 1;
    localparam logic [ADDR_WIDTH:0] SIZE_L = (ADDR_WIDTH+1)'(SIZE_BYTES);
    localparam logic [3:0] LAT_L  = 4'(LATENCY);
    // The second beat always costs at least one cycle, even with zero latency.
    localparam logic [3:0] LAT2_L = (LATENCY == 0) ? 4'd1 : 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, WAIT2, RESP} state_t;

    typedef struct packed {
        logic                  write;
        logic [1:0]            size;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                state;
    req_t                  req_q;
    req_t                  acc;
    logic [3:0]            cnt;
    logic [7:0]            mem [SIZE_BYTES];

    logic [2:0]            acc_n;
    logic                  acc_cross;
    logic                  acc_beat;
    logic                  in_err;
    logic                  do_acc;
    logic [3:0]            bmask;
    logic [3:0][MW-1:0]    bidx;
    logic [3:0][7:0]       rd_bytes;
    logic [DATA_WIDTH-1:0] rd_word;

    // In IDLE the access operands come straight from the request so a
    // zero-latency access can complete on the accept edge.
    always_comb begin
        acc = (state == IDLE) ? req_t'({req_write, req_size, req_addr, req_wdata}) : req_q;
        case (acc.size)
            2'd0:    acc_n = 3'd1;
            2'd1:    acc_n = 3'd2;
            default: acc_n = 3'd4;
        endcase
        in_err = (acc.size == 2'd3) ||
                 (({1'b0, acc.addr} + (ADDR_WIDTH+1)'(acc_n)) > SIZE_L);
`ifndef TOY_RAM_MISALIGN_SPLIT_EN
        in_err = in_err || (acc.size == 2'd1 && acc.addr[0]) ||
                           (acc.size == 2'd2 && acc.addr[1:0] != 2'd0);
`endif
`ifdef TOY_RAM_MISALIGN_SPLIT_EN
        acc_cross = ({1'b0, acc.addr[1:0]} + acc_n) > 3'd4;
`else
        acc_cross = 1'b0;
`endif
        acc_beat = (state == WAIT2);
        bmask    = '0;
        rd_word  = '0;
        bidx     = '0;
        rd_bytes = '0;
        for (int b = 0; b < 4; b++) begin
            // Bytes below the next word boundary belong to beat 0, the rest to beat 1.
            bmask[b]    = (3'(b) < acc_n) &&
                          (!acc_cross || ((({1'b0, acc.addr[1:0]} + 3'(b)) < 3'd4) ^ acc_beat));
            bidx[b]     = MW'(acc.addr + ADDR_WIDTH'(b));
            rd_bytes[b] = mem[bidx[b]];
            if (bmask[b] && !acc.write)
                rd_word[8*b +: 8] = rd_bytes[b];
            else if (acc_beat)
                rd_word[8*b +: 8] = rsp_rdata[8*b +: 8];
        end
        do_acc = ((state == IDLE) && req_valid && req_ready && !in_err && (LATENCY == 0)) ||
                 (((state == WAIT) || (state == WAIT2)) && (cnt == 4'd1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SIZE_BYTES; i++)
                mem[i] <= 8'h00;
        end else if (do_acc && acc.write) begin
            for (int b = 0; b < 4; b++)
                if (bmask[b])
                    mem[bidx[b]] <= acc.wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_q     <= '0;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q     <= acc;
                        req_ready <= 1'b0;
                        rsp_err   <= in_err;
                        rsp_rdata <= '0;
                        if (in_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else if (LATENCY == 0) begin
                            rsp_rdata <= rd_word;
                            if (acc_cross) begin
                                state <= WAIT2;
                                cnt   <= LAT2_L;
                            end else begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                            end
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_L;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        rsp_rdata <= rd_word;
                        if (acc_cross) begin
                            state <= WAIT2;
                            cnt   <= LAT2_L;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WAIT2: begin
                    if (cnt == 4'd1) begin
                        rsp_rdata <= rd_word;
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_toy_ram_hs.sv
// Bench for toy_ram_hs: cycle-level byte-array model with a per-cycle compare, plus directed literal checks.
module tb_toy_ram_hs;
`ifdef TOY_RAM_MISALIGN_SPLIT_EN
    localparam int LAT   = 2;
    localparam bit SPLIT = 1'b1;
    localparam int ALIGNED_LAT = 3;
`else
    localparam int LAT   = 1;
    localparam bit SPLIT = 1'b0;
    localparam int ALIGNED_LAT = 2;
`endif
    localparam int SIZE = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_chk = 0;
    int n_fail = 0;

    toy_ram_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .SIZE_BYTES(SIZE), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit [7:0] m_mem [0:SIZE-1];
    bit       m_busy = 1'b0;
    bit       m_err = 1'b0;
    bit [31:0] m_rdata = 32'h0;
    int       m_cyc = 0;
    int       m_acc = 0;
    int       m_d = 0;

    function automatic int f_n(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit f_err(input logic [1:0] sz, input logic [15:0] a);
        int n = f_n(sz);
        return (sz == 2'd3) || (int'(a) + n > SIZE) || (!SPLIT && (int'(a) % n) != 0);
    endfunction

    // Edges from accept until the response is visible.
    function automatic int f_d(input logic [1:0] sz, input logic [15:0] a);
        if (f_err(sz, a)) return 0;
        if (SPLIT && (int'(a) % 4) + f_n(sz) > 4) return (2 * LAT > 1) ? 2 * LAT : 1;
        return LAT;
    endfunction

    function automatic bit [31:0] f_rd(input logic w, input logic [1:0] sz, input logic [15:0] a);
        bit [31:0] v = 32'h0;
        if (w || f_err(sz, a)) return 32'h0;
        for (int i = 0; i < f_n(sz); i++) v |= 32'(m_mem[int'(a) + i]) << (8 * i);
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_cyc  <= 0;
            for (int i = 0; i < SIZE; i++) m_mem[i] <= 8'h00;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_busy) begin
                if (m_cyc >= m_acc + m_d && rsp_ready) m_busy <= 1'b0;
            end else if (req_valid) begin
                m_busy  <= 1'b1;
                m_acc   <= m_cyc + 1;
                m_err   <= f_err(req_size, req_addr);
                m_d     <= f_d(req_size, req_addr);
                m_rdata <= f_rd(req_write, req_size, req_addr);
                if (req_write && !f_err(req_size, req_addr))
                    for (int i = 0; i < f_n(req_size); i++)
                        m_mem[int'(req_addr) + i] <= req_wdata[8*i +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && (m_cyc >= m_acc + m_d)));
            if (m_busy && (m_cyc >= m_acc + m_d)) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic to_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic txn(input bit w, input bit [1:0] sz, input bit [15:0] a, input bit [31:0] wd,
                       input int hold, output bit [31:0] rd, output bit er, output int lat);
        int t;
        rd = 32'h0; er = 1'b0; lat = -1;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        if (!req_ready) begin to_fail("accept_timeout"); req_valid = 1'b0; return; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
        if (!rsp_valid) begin to_fail("rsp_timeout"); return; end
        rd = rsp_rdata; er = rsp_err;
        if (hold > 0) begin
            // A competing request during backpressure must be ignored.
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 16'h0; req_wdata = 32'hFFFF_FFFF;
            repeat (hold) @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rdata_stable", rsp_rdata, rd);
            chk("bp_err_stable", 32'(rsp_err), 32'(er));
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] rd;
        bit        er;
        int        lat;
        int        bad;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);

        txn(0, 2, 16'h0000, 0, 0, rd, er, lat);
        chk("read0_data", rd, 32'h0);
        chk("read0_err", 32'(er), 32'd0);

        txn(1, 2, 16'h0010, 32'h11223344, 0, rd, er, lat);
        chk("wr_word_data", rd, 32'h0);
        chk("wr_word_err", 32'(er), 32'd0);
        txn(0, 0, 16'h0012, 0, 0, rd, er, lat);
        chk("rd_byte12", rd, 32'h0000_0022);
        chk("rd_byte12_lat", 32'(lat), 32'(ALIGNED_LAT));
        txn(0, 1, 16'h0010, 0, 0, rd, er, lat);
        chk("rd_half10", rd, 32'h0000_3344);

        txn(1, 0, 16'h0013, 32'h0000_00AB, 0, rd, er, lat);
        txn(0, 2, 16'h0010, 0, 0, rd, er, lat);
        chk("rd_word_after_byte", rd, 32'hAB22_3344);

        txn(0, 2, 16'h0FFE, 0, 0, rd, er, lat);
        chk("oor_read_err", 32'(er), 32'd1);
        chk("oor_read_data", rd, 32'h0);
        chk("err_lat", 32'(lat), 32'd1);
        txn(1, 2, 16'h0FFE, 32'hCAFEF00D, 0, rd, er, lat);
        chk("oor_write_err", 32'(er), 32'd1);
        txn(0, 2, 16'h0FFC, 0, 0, rd, er, lat);
        chk("top_word_err", 32'(er), 32'd0);
        chk("top_word_data", rd, 32'h0);

        txn(1, 3, 16'h0010, 32'h55555555, 0, rd, er, lat);
        chk("size3_err", 32'(er), 32'd1);
        txn(0, 2, 16'h0010, 0, 0, rd, er, lat);
        chk("size3_mem_kept", rd, 32'hAB22_3344);

        txn(1, 1, 16'h0011, 32'h0000_BEEF, 0, rd, er, lat);
`ifdef TOY_RAM_MISALIGN_SPLIT_EN
        chk("mis_half_err", 32'(er), 32'd0);
        txn(0, 2, 16'h0010, 0, 0, rd, er, lat);
        chk("mis_half_mem", rd, 32'hABBE_EF44);
`else
        chk("mis_half_err", 32'(er), 32'd1);
        txn(0, 2, 16'h0010, 0, 0, rd, er, lat);
        chk("mis_half_mem", rd, 32'hAB22_3344);
`endif

        txn(0, 2, 16'h0010, 0, 5, rd, er, lat);
`ifdef TOY_RAM_MISALIGN_SPLIT_EN
        chk("bp_data", rd, 32'hABBE_EF44);
`else
        chk("bp_data", rd, 32'hAB22_3344);
`endif
        @(negedge clk);
        chk("bp_back_idle", 32'(req_ready), 32'd1);

        txn(1, 2, 16'h0006, 32'hDEADBEEF, 0, rd, er, lat);
`ifdef TOY_RAM_MISALIGN_SPLIT_EN
        chk("split_wr_err", 32'(er), 32'd0);
        txn(0, 2, 16'h0006, 0, 0, rd, er, lat);
        chk("split_rd_data", rd, 32'hDEADBEEF);
        chk("split_rd_lat", 32'(lat), 32'd5);
        txn(0, 1, 16'h0008, 0, 0, rd, er, lat);
        chk("split_hi_half", rd, 32'h0000_DEAD);
`else
        chk("mis_word_err", 32'(er), 32'd1);
        txn(0, 2, 16'h0004, 0, 0, rd, er, lat);
        chk("mis_word_mem", rd, 32'h0);
`endif

        // Reset while the access is still waiting.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 16'h0010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst = 1'b0;
        chk("rst_wait_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (4) begin @(negedge clk); if (rsp_valid) bad++; end
        chk("rst_wait_no_rsp", 32'(bad), 32'd0);
        chk("rst_wait_ready", 32'(req_ready), 32'd1);
        txn(0, 2, 16'h0010, 0, 0, rd, er, lat);
        chk("rst_mem_cleared", rd, 32'h0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/toy_ram_hs.md
Name: toy_ram_hs

Overview:
- Parametrised successor to the toy byte-array RAM.
- Byte-addressable, little-endian data memory with a valid/ready request channel and a valid/ready response channel.
- Supports byte, half and word accesses, a configurable access latency, and error reporting for misaligned, out-of-range and illegal-size requests.
- Sits between the core load/store unit and the toy memory map; one outstanding request at a time.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be 32.
- ADDR_WIDTH, 16, byte address width.
- SIZE_BYTES, 4096, memory capacity in bytes; must be at most 2^ADDR_WIDTH and a multiple of 4.
- LATENCY, 1, wait cycles between request accept and the memory access; range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_WIDTH  read data, right-justified, zero-extended
- rsp_err  out  1  request rejected; memory untouched

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; any pending request or response is dropped.
  - req_ready=1 after reset release; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All memory bytes are cleared to 0x00.
- Byte count: n = 1, 2 or 4 for req_size 0, 1, 2.
- Request accept: a request is accepted on a rising edge with req_valid && req_ready. On accept, write, size, addr and wdata are latched.
- Error check, evaluated on the latched request:
  - req_size==3 -> error.
  - addr+n > SIZE_BYTES -> error. Compute in ADDR_WIDTH+1 bits so the sum cannot wrap.
  - Misaligned (size 1 with addr[0]!=0; size 2 with addr[1:0]!=0) -> error.
- States:
  - IDLE: req_ready=1, rsp_valid=0.
    - On accept with an error, go to RESP with rsp_err=1 and rsp_rdata=0.
    - On accept, no error, LATENCY==0: perform the access on the accept edge and go to RESP.
    - On accept, no error, LATENCY>0: load counter=LATENCY and go to WAIT.
  - WAIT: req_ready=0. The counter decrements each cycle. When it reaches 1, perform the access on that edge and go to RESP.
  - RESP: req_ready=0, rsp_valid=1. rsp_rdata and rsp_err stay stable until a rising edge with rsp_ready=1, then go to IDLE.
- Turnaround: no new request is accepted in the RESP-exit cycle; back-to-back throughput is one request per LATENCY+2 cycles.
- Read data: bytes mem[addr..addr+n-1] in little-endian order, placed in rsp_rdata[8n-1:0]; upper bits are 0.
- Write: only mem[addr..addr+n-1] are updated, from wdata[8n-1:0]. rsp_rdata=0 on write responses. A write response is still issued and must be handshaked.
- Errored requests never modify memory.

Optional Feature:
- Macro: TOY_RAM_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned but in-range half/word accesses are legal.
  - An access crossing a 4-byte word boundary is split into two beats. Beat 1 covers the low word's bytes and beat 2 the high word's bytes.
  - Each beat incurs its own LATENCY wait, using a second WAIT phase (state WAIT2). Total accept-to-rsp_valid time is 2*LATENCY+1 cycles, minimum 2.
  - Misaligned accesses that do not cross a word boundary (e.g. half at addr%4==1) take a single beat.
  - The out-of-range check is unchanged and is applied before any beat, so a split access never partially writes.
- Undefined: misaligned requests return rsp_err=1 as above.

Test Plan:
- Reset then idle -> req_ready=1, rsp_valid=0, rsp_rdata=0; a word read at 0x0000 returns 0x00000000.
- LATENCY=1:
  - Word write 0x11223344 @0x0010, handshake.
  - Byte read @0x0012 -> rsp_rdata=0x00000022.
  - Half read @0x0010 -> 0x00003344.
  - rsp_valid exactly 2 cycles after accept.
- Byte write 0xAB @0x0013 over the above, then word read @0x0010 -> 0xAB223344; other bytes unchanged.
- Error cases, each with memory unchanged:
  - Word read @0x0FFE (SIZE_BYTES=4096) -> rsp_err=1.
  - req_size=3 -> rsp_err=1.
  - Half write @0x0011 without the macro -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0, a second req_valid is not accepted; release -> returns to IDLE.
- With TOY_RAM_MISALIGN_SPLIT_EN and LATENCY=2:
  - Word write 0xDEADBEEF @0x0006.
  - Word read @0x0006 -> 0xDEADBEEF, rsp_valid 5 cycles after accept.
- Reset asserted in WAIT -> rsp_valid never rises, memory is zeroed, and req_ready=1 after release.
